// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types and constants for the 1:4 TDM demultiplexer
package demux_pkg;

  localparam int NUM_SLOTS  = 4;
  localparam int MISS_LIMIT = 2;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Commands issued by the framing FSM to the slot/miss counter.
  typedef enum logic [2:0] {
    CTR_HOLD  = 3'd0,
    CTR_INC   = 3'd1,
    CTR_SYNC  = 3'd2,
    CTR_MISS  = 3'd3,
    CTR_CLEAR = 3'd4
  } ctr_op_t;

  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [1:0] s);
    return NUM_SLOTS'(1) << s;
  endfunction

endpackage

// File: rtl/demux_slot_ctr.sv
// rtl/demux_slot_ctr.sv - slot index and missed-frame counter driven by FSM commands
module demux_slot_ctr
  import demux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  ctr_op_t    op_i,
  output logic [1:0] slot_o,
  output logic [1:0] miss_o
);

  logic [1:0] slot_q, slot_d;
  logic [1:0] miss_q, miss_d;

  always_comb begin
    slot_d = slot_q;
    miss_d = miss_q;
    unique case (op_i)
      CTR_INC: slot_d = slot_q + 2'd1;
      CTR_SYNC: begin
        slot_d = 2'd1;
        miss_d = 2'd0;
      end
      CTR_MISS: begin
        slot_d = 2'd1;
        miss_d = miss_q + 2'd1;
      end
      CTR_CLEAR: begin
        slot_d = 2'd0;
        miss_d = 2'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q <= 2'd0;
      miss_q <= 2'd0;
    end else begin
      slot_q <= slot_d;
      miss_q <= miss_d;
    end
  end

  assign slot_o = slot_q;
  assign miss_o = miss_q;

endmodule

// File: rtl/demux1to4_tdm.sv
// rtl/demux1to4_tdm.sv - 1:4 TDM demux with frame lock; DEMUX1TO4_ERR_CNT_EN adds err_cnt
module demux1to4_tdm
  import demux_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  input  logic         fsync,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [3:0]   vld,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         sync_err
`ifdef DEMUX1TO4_ERR_CNT_EN
  ,
  output logic [7:0]   err_cnt
`endif
);

  state_t         state_q, state_d;
  logic [W-1:0]   y_q [NUM_SLOTS];
  logic [3:0]     vld_q, vld_d;
  logic           err_q, err_d;
  logic           take;
  logic [1:0]     tgt;
  ctr_op_t        op;
  logic [1:0]     slot_w;
  logic [1:0]     miss_w;

  demux_slot_ctr u_slot_ctr (
    .clk    (clk),
    .rst    (rst),
    .op_i   (op),
    .slot_o (slot_w),
    .miss_o (miss_w)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    tgt     = 2'd0;
    err_d   = 1'b0;
    op      = CTR_HOLD;
    if (en) begin
      if (state_q == HUNT) begin
        if (fsync) begin
          take    = 1'b1;
          state_d = LOCK;
          op      = CTR_SYNC;
        end
      end else if (fsync) begin
        // An fsync away from slot 0 still realigns the frame to it.
        take  = 1'b1;
        err_d = (slot_w != 2'd0);
        op    = CTR_SYNC;
      end else if (slot_w != 2'd0) begin
        take = 1'b1;
        tgt  = slot_w;
        op   = CTR_INC;
      end else if (miss_w != 2'(MISS_LIMIT - 1)) begin
        take = 1'b1;
        op   = CTR_MISS;
      end else begin
        err_d   = 1'b1;
        state_d = HUNT;
        op      = CTR_CLEAR;
      end
    end
  end

  assign vld_d = take ? slot_onehot(tgt) : 4'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      vld_q   <= 4'd0;
      err_q   <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) y_q[k] <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      if (take) y_q[tgt] <= din;
    end
  end

`ifdef DEMUX1TO4_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (err_d && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign y0       = y_q[0];
  assign y1       = y_q[1];
  assign y2       = y_q[2];
  assign y3       = y_q[3];
  assign vld      = vld_q;
  assign slot     = slot_w;
  assign locked   = (state_q == LOCK);
  assign sync_err = err_q;

endmodule

// File: tb/tb_demux1to4_tdm.sv
// tb/tb_demux1to4_tdm.sv - directed vector bench for demux1to4_tdm
module tb_demux1to4_tdm;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [0:0] din;
  logic       fsync;
  logic [0:0] y0, y1, y2, y3;
  logic [3:0] vld;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;
`ifdef DEMUX1TO4_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  demux1to4_tdm #(.W(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .din      (din),
    .fsync    (fsync),
    .y0       (y0),
    .y1       (y1),
    .y2       (y2),
    .y3       (y3),
    .vld      (vld),
    .slot     (slot),
    .locked   (locked),
    .sync_err (sync_err)
`ifdef DEMUX1TO4_ERR_CNT_EN
    ,
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // y is written y0..y3 left to right; vld[0] is the rightmost bit.
  typedef struct {
    logic       en;
    logic       fs;
    logic       din;
    logic [0:3] y;
    logic [3:0] vld;
    logic [1:0] slot;
    logic       lock;
    logic       err;
    logic [7:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic e, f, d, input logic [0:3] y, input logic [3:0] vl,
                             input logic [1:0] s, input logic lk, er, input logic [7:0] ec);
    vec_t r;
    r.en = e; r.fs = f; r.din = d; r.y = y; r.vld = vl;
    r.slot = s; r.lock = lk; r.err = er; r.ecnt = ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input vec_t e, input string tag);
    logic [0:3] ya;
    ya = {y0, y1, y2, y3};
    chk({tag, " y"}, 8'(ya), 8'(e.y));
    chk({tag, " vld"}, 8'(vld), 8'(e.vld));
    chk({tag, " slot"}, 8'(slot), 8'(e.slot));
    chk({tag, " locked"}, 8'(locked), 8'(e.lock));
    chk({tag, " sync_err"}, 8'(sync_err), 8'(e.err));
`ifdef DEMUX1TO4_ERR_CNT_EN
    chk({tag, " err_cnt"}, err_cnt, e.ecnt);
`endif
  endtask

  task automatic apply(input logic e, input logic f, input logic d);
    @(negedge clk);
    en = e; fsync = f; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fsync = 1'b0; din = 1'b0;

    // reset then hunt with no fsync
    tbl.push_back(v(1,0,1, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'd0));
    tbl.push_back(v(1,0,1, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'd0));
    tbl.push_back(v(1,0,1, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'd0));
    // two clean frames 1,0,1,1
    for (int f = 0; f < 2; f++) begin
      tbl.push_back(v(1,1,1, 4'b1000 | (f ? 4'b0011 : 4'b0000), 4'b0001, 2'd1, 1, 0, 8'd0));
      tbl.push_back(v(1,0,0, 4'b1000 | (f ? 4'b0011 : 4'b0000), 4'b0010, 2'd2, 1, 0, 8'd0));
      tbl.push_back(v(1,0,1, 4'b1010 | (f ? 4'b0001 : 4'b0000), 4'b0100, 2'd3, 1, 0, 8'd0));
      tbl.push_back(v(1,0,1, 4'b1011, 4'b1000, 2'd0, 1, 0, 8'd0));
    end
    // gapped enable, data 0,1,0,0; fsync while en=0 is ignored
    tbl.push_back(v(1,1,0, 4'b0011, 4'b0001, 2'd1, 1, 0, 8'd0));
    tbl.push_back(v(0,0,1, 4'b0011, 4'b0000, 2'd1, 1, 0, 8'd0));
    tbl.push_back(v(1,0,1, 4'b0111, 4'b0010, 2'd2, 1, 0, 8'd0));
    tbl.push_back(v(0,1,0, 4'b0111, 4'b0000, 2'd2, 1, 0, 8'd0));
    tbl.push_back(v(1,0,0, 4'b0101, 4'b0100, 2'd3, 1, 0, 8'd0));
    tbl.push_back(v(0,0,1, 4'b0101, 4'b0000, 2'd3, 1, 0, 8'd0));
    tbl.push_back(v(1,0,0, 4'b0100, 4'b1000, 2'd0, 1, 0, 8'd0));
    // early fsync at slot 2
    tbl.push_back(v(1,1,1, 4'b1100, 4'b0001, 2'd1, 1, 0, 8'd0));
    tbl.push_back(v(1,0,0, 4'b1000, 4'b0010, 2'd2, 1, 0, 8'd0));
    tbl.push_back(v(1,1,0, 4'b0000, 4'b0001, 2'd1, 1, 1, 8'd1));
    tbl.push_back(v(1,0,1, 4'b0100, 4'b0010, 2'd2, 1, 0, 8'd1));
    tbl.push_back(v(1,0,1, 4'b0110, 4'b0100, 2'd3, 1, 0, 8'd1));
    tbl.push_back(v(1,0,1, 4'b0111, 4'b1000, 2'd0, 1, 0, 8'd1));
    // two frames without fsync, then relock
    tbl.push_back(v(1,0,1, 4'b1111, 4'b0001, 2'd1, 1, 0, 8'd1));
    tbl.push_back(v(1,0,0, 4'b1011, 4'b0010, 2'd2, 1, 0, 8'd1));
    tbl.push_back(v(1,0,0, 4'b1001, 4'b0100, 2'd3, 1, 0, 8'd1));
    tbl.push_back(v(1,0,0, 4'b1000, 4'b1000, 2'd0, 1, 0, 8'd1));
    tbl.push_back(v(1,0,0, 4'b1000, 4'b0000, 2'd0, 0, 1, 8'd2));
    tbl.push_back(v(1,0,1, 4'b1000, 4'b0000, 2'd0, 0, 0, 8'd2));
    tbl.push_back(v(1,1,0, 4'b0000, 4'b0001, 2'd1, 1, 0, 8'd2));
    // one miss, then fsync clears it, so the next miss is again a first miss
    tbl.push_back(v(1,0,1, 4'b0100, 4'b0010, 2'd2, 1, 0, 8'd2));
    tbl.push_back(v(1,0,1, 4'b0110, 4'b0100, 2'd3, 1, 0, 8'd2));
    tbl.push_back(v(1,0,1, 4'b0111, 4'b1000, 2'd0, 1, 0, 8'd2));
    tbl.push_back(v(1,0,1, 4'b1111, 4'b0001, 2'd1, 1, 0, 8'd2));
    tbl.push_back(v(1,0,0, 4'b1011, 4'b0010, 2'd2, 1, 0, 8'd2));
    tbl.push_back(v(1,0,0, 4'b1001, 4'b0100, 2'd3, 1, 0, 8'd2));
    tbl.push_back(v(1,0,0, 4'b1000, 4'b1000, 2'd0, 1, 0, 8'd2));
    tbl.push_back(v(1,1,0, 4'b0000, 4'b0001, 2'd1, 1, 0, 8'd2));
    tbl.push_back(v(1,0,1, 4'b0100, 4'b0010, 2'd2, 1, 0, 8'd2));
    tbl.push_back(v(1,0,1, 4'b0110, 4'b0100, 2'd3, 1, 0, 8'd2));
    tbl.push_back(v(1,0,1, 4'b0111, 4'b1000, 2'd0, 1, 0, 8'd2));
    tbl.push_back(v(1,0,1, 4'b1111, 4'b0001, 2'd1, 1, 0, 8'd2));
    tbl.push_back(v(1,0,0, 4'b1011, 4'b0010, 2'd2, 1, 0, 8'd2));

    repeat (2) @(posedge clk);
    #1;
    cmp(v(0,0,0, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'd0), "reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].en, tbl[i].fs, tbl[i].din);
      cmp(tbl[i], $sformatf("v%0d", i));
    end

    // asynchronous reset mid-frame at slot 2, observed before the next edge
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1 cmp(v(0,0,0, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'd0), "async_rst");
    @(negedge clk);
    rst = 1'b0;
    apply(1, 0, 1);
    cmp(v(0,0,0, 4'b0000, 4'b0000, 2'd0, 0, 0, 8'd0), "post_rst_hunt");
    apply(1, 1, 1);
    cmp(v(0,0,0, 4'b1000, 4'b0001, 2'd1, 1, 0, 8'd0), "post_rst_lock");

`ifdef DEMUX1TO4_ERR_CNT_EN
    for (int i = 0; i < 300; i++) apply(1, 1, 0);
    chk("err_cnt_sat", err_cnt, 8'd255);
    chk("sat_sync_err", 8'(sync_err), 8'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
